sdp_x_x_mul_core_cfg_triosy_collect: RTL and testbench
======================================================

# sdp_x_x_mul_core_cfg_triosy_collect

Epoch-level collector for the SDP X-path multiplier core's configuration triosy handshakes. It sits directly downstream of the per-resource triosy wait-control stages (cfg_mul_op, cfg_mul_shift_value, cfg_mul_src, cfg_mul_bypass). It consumes their `biwt`/`bdwt` strobes, keeps one sticky completion flag per resource, and tracks which resources a core epoch is still waiting on. It returns per-resource `lz` acknowledge pulses, a core stall, and an epoch-done pulse with an epoch counter.

## Interface
Parameters:
- NCH, 4, number of triosy channels; bit i = resource i (0 op, 1 shift_value, 2 src, 3 bypass)
- CW, 8, epoch counter width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- nvdla_core_clk  in  1  core clock; all state on rising edge
- nvdla_core_rst  in  1  synchronous, active-high reset
- core_wen  in  1  core enable; low freezes FSM/pend/lz generation
- core_wten  in  1  core wait-tenure; qualifies `core_stall` only
- req_vld  in  1  core opens an epoch (single-cycle strobe)
- req_mask  in  NCH  channels the epoch must collect
- biwt  in  NCH  per-channel "input wait satisfied" from wait-control stages
- bdwt  in  NCH  per-channel "done wait" (consume) from wait-control stages
- bcwt  out  NCH  sticky per-channel completion flags
- pend  out  NCH  channels still outstanding in the current epoch
- lz  out  NCH  registered one-cycle acknowledge pulse per channel
- core_stall  out  1  core must hold
- epoch_done  out  1  one-cycle pulse at epoch completion
- epoch_cnt  out  CW  completed-epoch count, wraps
- req_ovf  out  1  sticky: req_vld seen outside IDLE

## Operation
- Reset: state=IDLE; bcwt, pend, lz, epoch_done, epoch_cnt, req_ovf all 0. Reset mid-epoch abandons the epoch and emits no lz or epoch_done.
- Per-channel done term: done[i] = bcwt[i] | biwt[i].
- bcwt[i] next = (bcwt[i] | biwt[i]) & ~bdwt[i] & ~clr[i].
  - This update runs every cycle, independent of core_wen and state.
  - bdwt wins over a same-cycle biwt for bcwt, but that cycle's biwt still counts toward done[i].
  - clr[i] = (state==FLUSH) & mask_q[i].
- FSM states: IDLE, COLLECT, FLUSH. All transitions require core_wen=1.
- IDLE:
  - req_vld & req_mask!=0: mask_q<=req_mask, pend<=req_mask, go to COLLECT.
  - req_vld & req_mask==0: go to FLUSH directly with mask_q=0.
- COLLECT:
  - pend[i] clears in any cycle where pend[i] & done[i].
  - lz[i] is set for exactly the next cycle after that clear.
  - When (pend & ~done)==0, go to FLUSH.
- FLUSH:
  - epoch_done=1 for this cycle.
  - epoch_cnt increments modulo 2^CW; 2^CW-1 wraps to 0.
  - Clears bcwt of mask_q channels; go to IDLE.
- req_vld in COLLECT or FLUSH is ignored and sets req_ovf. req_ovf clears only on reset.
- core_stall = core_wten & (state!=IDLE), combinational.
- core_wen=0: state, pend and mask_q hold, and lz is forced 0 that cycle. A clear that would have happened is deferred, not lost, because bcwt still captures biwt.
- Channels outside mask_q never affect pend, lz or completion, but their bcwt still tracks biwt/bdwt.

## Timing
- Minimum epoch latency: req_vld at cycle 0, all channels done in cycle 1 → FLUSH in cycle 2 (epoch_done=1, lz for cycle-1 completions=1) → IDLE in cycle 3.
- A biwt arriving while IDLE (cycle 0) is held in bcwt and completes the channel in cycle 1.
- lz latency is 1 cycle after the pend clear.
- epoch_done, epoch_cnt update, and the bcwt clear all occur in the FLUSH cycle. The epoch_cnt value is visible in the cycle after FLUSH.
- Back-to-back epochs: a new req_vld is accepted in the cycle after FLUSH at the earliest (1 dead cycle).

## Test plan
- Reset, then req_vld with mask=4'b0001; biwt[0] pulses at cycle 3 → lz[0]=1 at cycle 4, epoch_done=1 at cycle 4, epoch_cnt=1 at cycle 5; core_stall=1 (with core_wten=1) in cycles 1–4.
- mask=4'b1010 with biwt[1] at cycle 2 and biwt[3] at cycle 5 → pend=1010→1000→0000; lz[1] at cycle 3, lz[3] and epoch_done at cycle 6.
- biwt[2] pulsed while IDLE, then req mask=4'b0100 → completes in cycle 1, epoch_done in cycle 2; a same-cycle biwt[2]&bdwt[2] still completes the channel but leaves bcwt[2]=0.
- core_wen=0 for cycles 2–4 while biwt[0] pulses at cycle 2 (mask=0001) → no lz, state holds; core_wen returns at cycle 5 → lz[0] at cycle 6, epoch_done at cycle 6.
- req_vld during COLLECT → req_ovf=1 and stays 1; the epoch is unaffected; mask=0 request gives epoch_done at cycle 1 with no lz.
- Preload epoch_cnt to 255 via 255 epochs (CW=8), run one more → wraps to 0. Assert nvdla_core_rst mid-COLLECT → all outputs 0 next cycle, no epoch_done.

Source files
------------

// File: rtl/sdp_x_x_mul_core_cfg_triosy_collect.sv
// sdp_x_x_mul_core_cfg_triosy_collect: epoch collector for the multiplier core cfg triosy handshakes
module sdp_x_x_mul_core_cfg_triosy_collect #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  input  logic           core_wen,
  input  logic           core_wten,
  input  logic           req_vld,
  input  logic [NCH-1:0] req_mask,
  input  logic [NCH-1:0] biwt,
  input  logic [NCH-1:0] bdwt,
  output logic [NCH-1:0] bcwt,
  output logic [NCH-1:0] pend,
  output logic [NCH-1:0] lz,
  output logic           core_stall,
  output logic           epoch_done,
  output logic [CW-1:0]  epoch_cnt,
  output logic           req_ovf
);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, FLUSH = 2'd2;
  logic [1:0]     state, state_nx;
  logic [NCH-1:0] mask_q, done, clr;
  logic           idle, collect, flush;
  assign idle       = state == IDLE;
  assign collect    = state == COLLECT;
  assign flush      = state == FLUSH;
  assign done       = bcwt | biwt;
  assign clr        = {NCH{flush}} & mask_q;
  assign core_stall = core_wten & ~idle;
  assign epoch_done = core_wen & flush;
  // an empty request skips COLLECT; the unused encoding falls back to IDLE
  always_comb begin
    state_nx = !core_wen ? state :
               idle      ? (req_vld ? (|req_mask ? COLLECT : FLUSH) : IDLE) :
               collect   ? (|(pend & ~done) ? COLLECT : FLUSH) : IDLE;
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state     <= IDLE;
      mask_q    <= '0;
      pend      <= '0;
      lz        <= '0;
      bcwt      <= '0;
      epoch_cnt <= '0;
      req_ovf   <= 1'b0;
    end else begin
      bcwt    <= done & ~bdwt & ~clr;
      req_ovf <= req_ovf | (req_vld & ~idle);
      state   <= state_nx;
      lz      <= (core_wen & collect) ? pend & done : '0;
      if (core_wen & idle & req_vld) begin
        mask_q <= req_mask;
        pend   <= req_mask;
      end
      if (core_wen & collect) pend <= pend & ~done;
      if (epoch_done) epoch_cnt <= epoch_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sdp_x_x_mul_core_cfg_triosy_collect.sv
// tb_sdp_x_x_mul_core_cfg_triosy_collect: scoreboard bench for the cfg triosy collector
module tb_sdp_x_x_mul_core_cfg_triosy_collect;
  logic       clk = 1'b0, rst = 1'b1;
  logic       core_wen = 1'b0, core_wten = 1'b0, req_vld = 1'b0;
  logic [3:0] req_mask = '0, biwt = '0, bdwt = '0;
  logic [3:0] bcwt, pend, lz;
  logic       core_stall, epoch_done, req_ovf;
  logic [7:0] epoch_cnt;
  int checks = 0, fails = 0;
  logic [7:0] exp_cnt = '0;
  logic       exp_ovf = 1'b0;
  typedef struct packed {
    logic [3:0] pend, lz, bcwt;
    logic       stall, done;
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;
  exp_t q[$];

  sdp_x_x_mul_core_cfg_triosy_collect #(.NCH(4), .CW(8)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .core_wen(core_wen), .core_wten(core_wten),
    .req_vld(req_vld), .req_mask(req_mask), .biwt(biwt), .bdwt(bdwt), .bcwt(bcwt),
    .pend(pend), .lz(lz), .core_stall(core_stall), .epoch_done(epoch_done),
    .epoch_cnt(epoch_cnt), .req_ovf(req_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drive one cycle of inputs and queue the outputs expected during that same cycle
  task automatic cyc(input logic w, t, rv, input logic [3:0] rm, bi, bd, ep, el,
                     input logic es, ed, input logic [3:0] eb);
    exp_t e;
    core_wen = w; core_wten = t; req_vld = rv; req_mask = rm; biwt = bi; bdwt = bd;
    e.pend = ep; e.lz = el; e.bcwt = eb; e.stall = es; e.done = ed;
    e.cnt = exp_cnt; e.ovf = exp_ovf;
    q.push_back(e);
    if (ed) exp_cnt = exp_cnt + 8'd1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pend", pend, e.pend);
      chk("lz", lz, e.lz);
      chk("bcwt", bcwt, e.bcwt);
      chk("core_stall", core_stall, e.stall);
      chk("epoch_done", epoch_done, e.done);
      chk("epoch_cnt", epoch_cnt, e.cnt);
      chk("req_ovf", req_ovf, e.ovf);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // single channel, late biwt
    cyc(1,1,1,4'h1,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h1,4'h0,1,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h1,4'h0,1,0,4'h0);
    cyc(1,1,0,4'h0,4'h1,4'h0, 4'h1,4'h0,1,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h1,1,1,4'h1);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // two channels plus an unmasked channel that only tracks in bcwt
    cyc(1,1,1,4'ha,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'ha,4'h0,1,0,4'h0);
    cyc(1,1,0,4'h0,4'h3,4'h0, 4'ha,4'h0,1,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h8,4'h2,1,0,4'h3);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h8,4'h0,1,0,4'h3);
    cyc(1,1,0,4'h0,4'h8,4'h0, 4'h8,4'h0,1,0,4'h3);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h8,1,1,4'hb);
    cyc(1,1,0,4'h0,4'h0,4'h1, 4'h0,4'h0,0,0,4'h1);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // biwt held from IDLE completes in the first COLLECT cycle
    cyc(1,1,0,4'h0,4'h4,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,1,4'h4,4'h0,4'h0, 4'h0,4'h0,0,0,4'h4);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h4,4'h0,1,0,4'h4);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h4,1,1,4'h4);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // same-cycle biwt and bdwt: completes the channel, bcwt stays clear
    cyc(1,1,1,4'h4,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,0,4'h0,4'h4,4'h4, 4'h4,4'h0,1,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h4,1,1,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // core_wen low defers the clear; core_wten low drops the stall
    cyc(1,1,1,4'h1,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h1,4'h0,1,0,4'h0);
    cyc(0,1,0,4'h0,4'h1,4'h0, 4'h1,4'h0,1,0,4'h0);
    cyc(0,1,0,4'h0,4'h0,4'h0, 4'h1,4'h0,1,0,4'h1);
    cyc(0,0,0,4'h0,4'h0,4'h0, 4'h1,4'h0,0,0,4'h1);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h1,4'h0,1,0,4'h1);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h1,1,1,4'h1);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // request during COLLECT is ignored and flagged
    cyc(1,1,1,4'h1,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,1,4'hf,4'h0,4'h0, 4'h1,4'h0,1,0,4'h0);
    exp_ovf = 1'b1;
    cyc(1,1,0,4'h0,4'h1,4'h0, 4'h1,4'h0,1,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h1,1,1,4'h1);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // empty request goes straight to FLUSH
    cyc(1,1,1,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,1,1,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // run empty epochs up to 255, then one more to wrap
    while (exp_cnt != 8'hff) begin
      cyc(1,1,1,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
      cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,1,1,4'h0);
    end
    cyc(1,1,1,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,1,1,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    // reset mid-COLLECT abandons the epoch
    cyc(1,1,1,4'h3,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h3,4'h0,1,0,4'h0);
    biwt = 4'h3; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = '0; exp_ovf = 1'b0;
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    cyc(1,1,0,4'h0,4'h0,4'h0, 4'h0,4'h0,0,0,4'h0);
    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
